spi_cmd_sequencer: RTL and testbench

//  Upstream feeder for spi_master: queues software SPI commands {chip-select, word} in a command FIFO.

---
 rtl/spi_seq_pkg.sv | 18 +
 rtl/spi_seq_fifo.sv | 51 +++++
 rtl/spi_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: FSM state encoding and
// FIFO pointer sizing.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } seq_state_t;

  // The extra MSB tells full from empty when the index bits are equal.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous first-word fall-through FIFO; rdata shows the head while !empty.
// A write is accepted when full only if a read frees a slot in the same cycle.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW    = ptr_width(DEPTH_LOG2);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Feeds queued {cs, word} commands to spi_master one at a time and collects
// each readback word, with a timeout per transfer and an idle gap afterwards.
//
// state   | meaning
// IDLE    | nothing in flight; launch when a command is queued
// LAUNCH  | present head command, pulse m_trigger, pop command FIFO
// WAIT    | wait for m_dvld (capture + ack) or timeout
// RELEASE | hold m_ack until spi_master drops m_dvld
// GAP     | enforce chip-select idle time before the next launch
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NBITS      = 24,
  parameter int NCS        = 3,
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_wr,
  input  logic [NCS-1:0]   cmd_cs,
  input  logic [NBITS-1:0] cmd_data,
  output logic             cmd_full,
  input  logic [NCS-1:0]   cs_idle,
  input  logic             rsp_rd,
  output logic [NBITS-1:0] rsp_data,
  output logic             rsp_empty,
  output logic             busy,
  input  logic             err_clr,
  output logic             err_cmd_ovf,
  output logic             err_rsp_ovf,
  output logic             err_timeout,
  output logic [NCS-1:0]   m_cs_in,
  output logic [NCS-1:0]   m_cs_in_idle,
  output logic [NBITS-1:0] m_din,
  output logic             m_trigger,
  output logic             m_ack,
  input  logic [NBITS-1:0] m_dout,
  input  logic             m_dvld
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_SAT  = '1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  seq_state_t state;
  seq_state_t state_next;

  logic [NCS+NBITS-1:0] cmd_head;
  logic                 cmd_empty;
  logic                 cmd_pop;
  logic                 rsp_full;
  logic                 rsp_push;
  logic [TW-1:0]        tmo_cnt;
  logic                 tmo_evt;
  logic [GW-1:0]        gap_cnt;
  logic                 cmd_ovf_evt;
  logic                 rsp_ovf_evt;

  spi_seq_fifo #(
    .WIDTH      (NCS + NBITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (cmd_wr),
    .wdata ({cmd_cs, cmd_data}),
    .rd    (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  spi_seq_fifo #(
    .WIDTH      (NBITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (rsp_push),
    .wdata (m_dout),
    .rd    (rsp_rd),
    .rdata (rsp_data),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  // A full FIFO is never empty, so a concurrent read always frees a slot.
  assign cmd_ovf_evt = cmd_wr && cmd_full && !cmd_pop;
  assign rsp_ovf_evt = rsp_push && rsp_full && !rsp_rd;
  assign tmo_evt     = (state == ST_WAIT) && !m_dvld && (tmo_cnt == TMO_LAST);
  assign busy        = (state != ST_IDLE) || !cmd_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (!cmd_empty) state_next = ST_LAUNCH;
      ST_LAUNCH:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (m_dvld)       state_next = ST_RELEASE;
        else if (tmo_evt) state_next = ST_GAP;
      end
      ST_RELEASE: if (!m_dvld) state_next = ST_GAP;
      ST_GAP:     if (gap_cnt == '0) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_trigger = 1'b0;
    m_ack     = 1'b0;
    m_din     = '0;
    m_cs_in   = '0;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    unique case (state)
      ST_LAUNCH: begin
        m_trigger = 1'b1;
        m_din     = cmd_head[NBITS-1:0];
        m_cs_in   = cmd_head[NCS+NBITS-1:NBITS];
        cmd_pop   = 1'b1;
      end
      ST_WAIT: begin
        m_ack    = m_dvld;
        rsp_push = m_dvld;
      end
      ST_RELEASE: m_ack = m_dvld;
      default: ;
    endcase
  end

  // Zeroed on the way into LAUNCH so the limit is measured from the trigger cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        tmo_cnt <= '0;
    else if (state_next == ST_LAUNCH)  tmo_cnt <= '0;
    else if (tmo_cnt != TMO_SAT)       tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                gap_cnt <= '0;
    else if (state != ST_GAP)  gap_cnt <= GAP_LOAD;
    else if (gap_cnt != '0)    gap_cnt <= gap_cnt - GW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cs_in_idle <= '0;
      err_cmd_ovf  <= 1'b0;
      err_rsp_ovf  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      m_cs_in_idle <= cs_idle;
      err_cmd_ovf  <= (err_cmd_ovf && !err_clr) || cmd_ovf_evt;
      err_rsp_ovf  <= (err_rsp_ovf && !err_clr) || rsp_ovf_evt;
      err_timeout  <= (err_timeout && !err_clr) || tmo_evt;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer; a behavioural SPI master answers each
// trigger with the bitwise inverse of m_din (miso = ~mosi loopback).
module tb_spi_cmd_sequencer;

  localparam int NBITS = 24;
  localparam int NCS   = 3;
  localparam int LAT   = 30;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_wr;
  logic [NCS-1:0]   cmd_cs;
  logic [NBITS-1:0] cmd_data;
  logic             cmd_full;
  logic [NCS-1:0]   cs_idle;
  logic             rsp_rd;
  logic [NBITS-1:0] rsp_data;
  logic             rsp_empty;
  logic             busy;
  logic             err_clr;
  logic             err_cmd_ovf;
  logic             err_rsp_ovf;
  logic             err_timeout;
  logic [NCS-1:0]   m_cs_in;
  logic [NCS-1:0]   m_cs_in_idle;
  logic [NBITS-1:0] m_din;
  logic             m_trigger;
  logic             m_ack;
  logic [NBITS-1:0] m_dout;
  logic             m_dvld;

  // behavioural master state
  logic             detach;
  logic             mdl_busy;
  logic [NBITS-1:0] mdl_din;
  int               mdl_cnt;
  int               trig_count;
  int               ack_count;
  logic [NCS-1:0]   trig_cs [128];

  int n_checks;
  int n_pass;

  spi_cmd_sequencer #(
    .NBITS      (NBITS),
    .NCS        (NCS),
    .DEPTH_LOG2 (4),
    .GAP_CYCLES (4),
    .TIMEOUT    (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_wr       (cmd_wr),
    .cmd_cs       (cmd_cs),
    .cmd_data     (cmd_data),
    .cmd_full     (cmd_full),
    .cs_idle      (cs_idle),
    .rsp_rd       (rsp_rd),
    .rsp_data     (rsp_data),
    .rsp_empty    (rsp_empty),
    .busy         (busy),
    .err_clr      (err_clr),
    .err_cmd_ovf  (err_cmd_ovf),
    .err_rsp_ovf  (err_rsp_ovf),
    .err_timeout  (err_timeout),
    .m_cs_in      (m_cs_in),
    .m_cs_in_idle (m_cs_in_idle),
    .m_din        (m_din),
    .m_trigger    (m_trigger),
    .m_ack        (m_ack),
    .m_dout       (m_dout),
    .m_dvld       (m_dvld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NBITS-1:0] bdat(input int i);
    return 24'h0f1e2d + 24'(i) * 24'h010203;
  endfunction

  function automatic logic [NBITS-1:0] fdat(input int i);
    return 24'ha50000 + 24'(i) * 24'h000111;
  endfunction

  task automatic push_cmd(input logic [NCS-1:0] cs, input logic [NBITS-1:0] d);
    cmd_wr   = 1'b1;
    cmd_cs   = cs;
    cmd_data = d;
    @(negedge clk);
    cmd_wr   = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_rd = 1'b1;
    @(negedge clk);
    rsp_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rsp_empty), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_trigger(input string tag);
    int n = 0;
    while (!m_trigger && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(m_trigger), 32'd1);
  endtask

  // Master: fixed latency, holds dvld until acked, resets with the block.
  initial begin
    mdl_busy   = 1'b0;
    mdl_din    = '0;
    mdl_cnt    = 0;
    m_dvld     = 1'b0;
    m_dout     = '0;
    trig_count = 0;
    ack_count  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_busy = 1'b0;
        m_dvld   = 1'b0;
      end else if (m_dvld) begin
        if (m_ack) begin
          m_dvld   = 1'b0;
          mdl_busy = 1'b0;
          ack_count++;
        end
      end else if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          m_dvld = 1'b1;
          m_dout = ~mdl_din;
        end else begin
          mdl_cnt--;
        end
      end else if (m_trigger) begin
        if (trig_count < 128) trig_cs[trig_count] = m_cs_in;
        trig_count++;
        if (!detach) begin
          mdl_busy = 1'b1;
          mdl_din  = m_din;
          mdl_cnt  = LAT;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int acks0;
    logic [NBITS-1:0] exp_d;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    cmd_wr   = 1'b0;
    cmd_cs   = '0;
    cmd_data = '0;
    cs_idle  = 3'b111;
    rsp_rd   = 1'b0;
    err_clr  = 1'b0;
    detach   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_trigger", 32'(m_trigger), 32'd0);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_cmd_full", 32'(cmd_full), 32'd0);
    chk("rst_rsp_empty", 32'(rsp_empty), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", 32'({err_cmd_ovf, err_rsp_ovf, err_timeout}), 32'd0);
    chk("rst_m_din", 32'(m_din), 32'd0);
    chk("rst_m_cs_in", 32'(m_cs_in), 32'd0);
    chk("rst_cs_idle_out", 32'(m_cs_in_idle), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cs_idle_copy", 32'(m_cs_in_idle), 32'h7);

    // single transfer, launch latency and busy release after the gap
    base = trig_count;
    push_cmd(3'b000, 24'hdeadbe);
    chk("single_trig_early", 32'(m_trigger), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_trig", 32'(m_trigger), 32'd1);
    chk("single_din", 32'(m_din), 32'hdeadbe);
    chk("single_cs", 32'(m_cs_in), 32'd0);
    @(negedge clk);
    chk("single_trig_pulse", 32'(m_trigger), 32'd0);
    chk("single_din_zero", 32'(m_din), 32'd0);
    wait_rsp("single_rsp_arrive");
    chk("single_rsp", 32'(rsp_data), 32'h215241);
    chk("single_busy_release", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("single_busy_fall", 32'(n), 32'd6);
    chk("single_trig_count", 32'(trig_count - base), 32'd1);
    pop_rsp();
    chk("single_rsp_empty", 32'(rsp_empty), 32'd1);

    // command FIFO fill while a transfer is in flight, overflow, clear vs set
    base = trig_count;
    push_cmd(3'd0, bdat(0));
    wait_trigger("burst_launch");
    for (int i = 1; i <= 16; i++) push_cmd(3'(i), bdat(i));
    chk("burst_full", 32'(cmd_full), 32'd1);
    chk("burst_no_ovf", 32'(err_cmd_ovf), 32'd0);
    push_cmd(3'd1, 24'h777777);
    chk("burst_ovf", 32'(err_cmd_ovf), 32'd1);
    pulse_clr();
    chk("burst_ovf_clr", 32'(err_cmd_ovf), 32'd0);
    err_clr = 1'b1;
    push_cmd(3'd2, 24'h888888);
    err_clr = 1'b0;
    chk("clr_vs_set", 32'(err_cmd_ovf), 32'd1);
    chk("burst_still_full", 32'(cmd_full), 32'd1);
    for (int i = 0; i <= 16; i++) begin
      wait_rsp($sformatf("burst_arrive_%0d", i));
      exp_d = ~bdat(i);
      chk($sformatf("burst_rsp_%0d", i), 32'(rsp_data), 32'(exp_d));
      pop_rsp();
    end
    wait_idle("burst_idle", 200);
    chk("burst_drained", 32'(rsp_empty), 32'd1);
    chk("burst_trig_count", 32'(trig_count - base), 32'd17);
    for (int i = 0; i <= 16; i++)
      chk($sformatf("burst_cs_%0d", i), 32'(trig_cs[base + i]), 32'(i % 8));
    chk("burst_rsp_ovf", 32'(err_rsp_ovf), 32'd0);
    pulse_clr();

    // response FIFO overflow without reads; every dvld still acked
    acks0 = ack_count;
    for (int i = 0; i <= 16; i++) push_cmd(3'(i), fdat(i));
    chk("fill_no_cmd_ovf", 32'(err_cmd_ovf), 32'd0);
    wait_idle("fill_idle", 3000);
    chk("fill_rsp_ovf", 32'(err_rsp_ovf), 32'd1);
    chk("fill_acks", 32'(ack_count - acks0), 32'd17);
    chk("fill_rsp_not_empty", 32'(rsp_empty), 32'd0);
    pulse_clr();
    chk("fill_ovf_clr", 32'(err_rsp_ovf), 32'd0);

    // push and pop on the full response FIFO in the same cycle
    push_cmd(3'd5, 24'hc0ffee);
    n = 0;
    while (!m_dvld && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pp_dvld", 32'(m_dvld), 32'd1);
    rsp_rd = 1'b1;
    @(negedge clk);
    rsp_rd = 1'b0;
    wait_idle("pp_idle", 200);
    chk("pp_no_ovf", 32'(err_rsp_ovf), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      exp_d = ~fdat(i);
      chk($sformatf("fill_rsp_%0d", i), 32'(rsp_data), 32'(exp_d));
      pop_rsp();
    end
    chk("pp_tail", 32'(rsp_data), 32'h3f0011);
    pop_rsp();
    chk("pp_empty", 32'(rsp_empty), 32'd1);

    // detached master: timeout after 64 clks, next command after the gap
    detach = 1'b1;
    base   = trig_count;
    push_cmd(3'd3, 24'h111111);
    push_cmd(3'd4, 24'h222222);
    wait_trigger("tmo_launch");
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'd64);
    chk("tmo_rsp_empty", 32'(rsp_empty), 32'd1);
    n = 0;
    while (!m_trigger && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_next_launch", 32'(n), 32'd6);
    wait_idle("tmo_idle", 400);
    chk("tmo_rsp_still_empty", 32'(rsp_empty), 32'd1);
    chk("tmo_trig_count", 32'(trig_count - base), 32'd2);
    chk("tmo_flag", 32'(err_timeout), 32'd1);
    detach = 1'b0;
    pulse_clr();
    chk("tmo_clr", 32'(err_timeout), 32'd0);

    // reset during WAIT with three commands queued
    for (int i = 0; i < 4; i++) push_cmd(3'd6, 24'h400000 + 24'(i));
    repeat (3) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_trigger", 32'(m_trigger), 32'd0);
    chk("mid_ack", 32'(m_ack), 32'd0);
    chk("mid_cmd_full", 32'(cmd_full), 32'd0);
    chk("mid_rsp_empty", 32'(rsp_empty), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_busy_after", 32'(busy), 32'd0);
    push_cmd(3'b010, 24'h00ff00);
    wait_rsp("mid_fresh_arrive");
    chk("mid_fresh_rsp", 32'(rsp_data), 32'hff00ff);
    pop_rsp();
    wait_idle("mid_fresh_idle", 200);
    chk("mid_fresh_empty", 32'(rsp_empty), 32'd1);
    chk("mid_errs", 32'({err_cmd_ovf, err_rsp_ovf, err_timeout}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
